// File: rtl/che_cdf_map.sv
// che_cdf_map: converts one clipped tile histogram into a gray-level mapping
// table for contrast-limited histogram equalisation.
//
// The clipped excess is spread evenly over all bins (remainder going to the
// lowest bins). The bins are then accumulated into a saturating CDF, and each
// CDF value is scaled onto the output gray range, giving one map entry per cycle.
//
// Build option: define CHE_CDF_ROUND_EN to round map entries to nearest.
// Without it they are truncated. Timing and ports are the same in both builds.
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   vld_i             a tile histogram is presented
//   hist_i            clipped bins, bin k at [k*BIN_WD +: BIN_WD]
//   excess_i          number of pixels removed by clipping
//   rdy_o             high while a tile can be accepted (IDLE only)
//   map_vld_o         map entry valid (BIN_NUM contiguous cycles per tile)
//   map_idx_o         bin index of the current entry
//   map_dat_o         mapped gray level of the current entry
//   done_o            pulse alongside the last entry of a tile
module che_cdf_map #(
  parameter int unsigned BIN_NUM   = 16,
  parameter int unsigned BIN_WD    = 12,
  parameter int unsigned EXC_WD    = 12,
  parameter int unsigned TILE_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       vld_i,
  input  logic [BIN_NUM*BIN_WD-1:0]  hist_i,
  input  logic [EXC_WD-1:0]          excess_i,
  output logic                       rdy_o,
  output logic                       map_vld_o,
  output logic [$clog2(BIN_NUM)-1:0] map_idx_o,
  output logic [$clog2(BIN_NUM)-1:0] map_dat_o,
  output logic                       done_o
);

  localparam int unsigned IW   = $clog2(BIN_NUM);
  localparam int unsigned SH   = 2 * TILE_LOG2;
  localparam int unsigned CW   = SH + 1;
  localparam int unsigned INW  = EXC_WD - IW;
  localparam int unsigned MX1  = (BIN_WD > CW) ? BIN_WD : CW;
  localparam int unsigned MX2  = (MX1 > INW) ? MX1 : INW;
  // Sum of cdf + bin + inc + 1 cannot overflow this width.
  localparam int unsigned AW   = MX2 + 2;
  // Scaled product plus rounding offset fits here.
  localparam int unsigned PW   = CW + IW + 1;
  localparam logic [CW-1:0] CDF_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIST = 2'd1,
    ACC  = 2'd2
  } state_t;

  state_t                    r_state;
  logic [BIN_NUM*BIN_WD-1:0] r_hist;
  logic [EXC_WD-1:0]         r_exc;
  logic [INW-1:0]            r_inc;
  logic [IW-1:0]             r_rem;
  logic [IW-1:0]             r_idx;
  logic [CW-1:0]             r_cdf;

  logic [BIN_WD-1:0]         w_bin;
  logic                      w_extra;
  logic [AW-1:0]             w_sum;
  logic [CW-1:0]             w_cdf_nxt;
  logic [PW-1:0]             w_prod;
  logic [PW-1:0]             w_scaled;
  logic [PW-1:0]             w_map_full;
  logic [IW-1:0]             w_map;

  // Per-bin CDF step and its scaled map value.
  always_comb begin
    w_bin     = r_hist[r_idx*BIN_WD +: BIN_WD];
    w_extra   = (r_idx < r_rem);
    w_sum     = AW'(r_cdf) + AW'(w_bin) + AW'(r_inc) + AW'(w_extra);
    w_cdf_nxt = (w_sum > AW'(CDF_MAX)) ? CDF_MAX : CW'(w_sum);
    w_prod    = PW'(w_cdf_nxt) * PW'(BIN_NUM - 1);
`ifdef CHE_CDF_ROUND_EN
    w_scaled  = w_prod + (PW'(1) << (SH - 1));
`else
    w_scaled  = w_prod;
`endif
    w_map_full = w_scaled >> SH;
    w_map      = (w_map_full > PW'(BIN_NUM - 1)) ? IW'(BIN_NUM - 1) : IW'(w_map_full);
  end

  // Tile FSM with registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_hist    <= '0;
      r_exc     <= '0;
      r_inc     <= '0;
      r_rem     <= '0;
      r_idx     <= '0;
      r_cdf     <= '0;
      rdy_o     <= 1'b1;
      map_vld_o <= 1'b0;
      map_idx_o <= '0;
      map_dat_o <= '0;
      done_o    <= 1'b0;
    end else begin
      map_vld_o <= 1'b0;
      done_o    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (vld_i) begin
            r_hist  <= hist_i;
            r_exc   <= excess_i;
            r_cdf   <= '0;
            rdy_o   <= 1'b0;
            r_state <= DIST;
          end
        end
        DIST: begin
          r_inc   <= INW'(r_exc >> IW);
          r_rem   <= IW'(r_exc);
          r_idx   <= '0;
          r_state <= ACC;
        end
        ACC: begin
          r_cdf     <= w_cdf_nxt;
          map_vld_o <= 1'b1;
          map_idx_o <= r_idx;
          map_dat_o <= w_map;
          r_idx     <= r_idx + 1'b1;
          if (r_idx == IW'(BIN_NUM - 1)) begin
            done_o  <= 1'b1;
            rdy_o   <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          rdy_o   <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_che_cdf_map.sv
// Self-checking bench for che_cdf_map (BIN_NUM=16, TILE_LOG2=4).
module tb_che_cdf_map;

  localparam int BN   = 16;
  localparam int BW   = 12;
  localparam int EW   = 12;
  localparam int HW   = BN * BW;
  localparam int SH   = 8;
  localparam int CMAX = 511;
`ifdef CHE_CDF_ROUND_EN
  localparam int RND  = 128;
`else
  localparam int RND  = 0;
`endif

  typedef struct {
    bit vld;
    int idx;
    int dat;
    bit done;
    int cyc;
  } ent_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          vld_i = 1'b0;
  logic [HW-1:0] hist_i = '0;
  logic [EW-1:0] excess_i = '0;
  logic          rdy_o;
  logic          map_vld_o;
  logic [3:0]    map_idx_o;
  logic [3:0]    map_dat_o;
  logic          done_o;

  ent_t exp_q[$];
  ent_t obs_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  che_cdf_map #(.BIN_NUM(BN), .BIN_WD(BW), .EXC_WD(EW), .TILE_LOG2(4)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .vld_i    (vld_i),
    .hist_i   (hist_i),
    .excess_i (excess_i),
    .rdy_o    (rdy_o),
    .map_vld_o(map_vld_o),
    .map_idx_o(map_idx_o),
    .map_dat_o(map_dat_o),
    .done_o   (done_o)
  );

  always #5 clk = ~clk;

  // Edge counter and accept recorder.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rstn && vld_i && rdy_o) acc_q.push_back(cyc);
  end

  // Output recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn && (map_vld_o || done_o))
      obs_q.push_back('{map_vld_o, int'(map_idx_o), int'(map_dat_o), done_o, cyc});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: push the expected map table for one tile.
  task automatic push_model(input logic [HW-1:0] h, input int ex);
    int cdf, inc, rem, m;
    cdf = 0;
    inc = ex / BN;
    rem = ex % BN;
    for (int k = 0; k < BN; k++) begin
      cdf = cdf + int'(h[k*BW +: BW]) + inc + ((k < rem) ? 1 : 0);
      if (cdf > CMAX) cdf = CMAX;
      m = (cdf * (BN - 1) + RND) >> SH;
      if (m > BN - 1) m = BN - 1;
      exp_q.push_back('{1'b1, k, m, (k == BN - 1), 0});
    end
  endtask

  task automatic build_pattern(input int p, output logic [HW-1:0] h, output int ex);
    h = '0;
    case (p)
      0: begin for (int k = 0; k < BN; k++) h[k*BW +: BW] = BW'(16); ex = 0; end
      1: begin h[5*BW +: BW] = BW'(64); ex = 192; end
      2: begin h[15*BW +: BW] = BW'(236); ex = 20; end
      default: begin for (int k = 0; k < BN; k++) h[k*BW +: BW] = '1; ex = 4095; end
    endcase
  endtask

  task automatic send_tile(input logic [HW-1:0] h, input int ex);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy_o && n < 100) begin @(negedge clk); n++; end
    hist_i   = h;
    excess_i = EW'(ex);
    vld_i    = 1'b1;
    push_model(h, ex);
    @(negedge clk);
    vld_i = 1'b0;
  endtask

  task automatic wait_obs(input int cnt);
    int n;
    n = 0;
    while (obs_q.size() < cnt && n < 120) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rdy_o !== 1'b1 || map_vld_o !== 1'b0 || map_idx_o !== 4'd0 ||
        map_dat_o !== 4'd0 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: rdy=%b vld=%b idx=%0d dat=%0d done=%b, need 1 0 0 0 0",
               rdy_o, map_vld_o, map_idx_o, map_dat_o, done_o);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Pattern 0 uniform, 1 clipped spike, 2 remainder, 3 overflow.
  task automatic test_map(input int p);
    logic [HW-1:0] h;
    int   ex;
    int   got[BN];
    int   ck_k[3];
    int   ck_v[3];
    ent_t o, e;
    bit   mono;
    for (int k = 0; k < BN; k++) got[k] = -1;
    obs_q.delete();
    exp_q.delete();
    build_pattern(p, h, ex);
    send_tile(h, ex);
    wait_obs(BN);
    n_cmp++;
    if (obs_q.size() != BN) begin
      n_err++;
      $display("FAIL map%0d_count: got %0d entries, need %0d", p, obs_q.size(), BN);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o.idx >= 0 && o.idx < BN) got[o.idx] = o.dat;
      n_cmp++;
      if (o.vld !== 1'b1 || o.idx != e.idx || o.dat != e.dat || o.done !== e.done) begin
        n_err++;
        $display("FAIL map%0d_entry: got vld=%b idx=%0d dat=%0d done=%b, need idx=%0d dat=%0d done=%b",
                 p, o.vld, o.idx, o.dat, o.done, e.idx, e.dat, e.done);
      end
    end
    obs_q.delete();
    exp_q.delete();
    case (p)
`ifdef CHE_CDF_ROUND_EN
      0: begin ck_k = '{0, 7, 15}; ck_v = '{1, 8, 15}; end
      1: begin ck_k = '{0, 5, 15}; ck_v = '{1, 8, 15}; end
`else
      0: begin ck_k = '{0, 7, 15}; ck_v = '{0, 7, 15}; end
      1: begin ck_k = '{0, 5, 15}; ck_v = '{0, 7, 15}; end
`endif
      2: begin ck_k = '{3, 14, 15}; ck_v = '{0, 1, 15}; end
      default: begin ck_k = '{0, 7, 15}; ck_v = '{15, 15, 15}; end
    endcase
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (got[ck_k[i]] != ck_v[i]) begin
        n_err++;
        $display("FAIL map%0d_known[%0d]: got %0d, need %0d", p, ck_k[i], got[ck_k[i]], ck_v[i]);
      end
    end
    mono = 1'b1;
    for (int k = 1; k < BN; k++) if (got[k] < got[k-1]) mono = 1'b0;
    n_cmp++;
    if (!mono) begin
      n_err++;
      $display("FAIL map%0d_monotonic: got non-monotonic table, need non-decreasing", p);
    end
  endtask

  task automatic test_back_to_back();
    logic [HW-1:0] hu, hs;
    int   exu, exs, a0;
    ent_t o, e;
    obs_q.delete();
    exp_q.delete();
    build_pattern(0, hu, exu);
    build_pattern(1, hs, exs);
    @(negedge clk);
    acc_q.delete();
    hist_i = hu; excess_i = EW'(exu); vld_i = 1'b1;
    push_model(hu, exu);
    @(negedge clk);
    // Busy-time data differs; only the tile at the next ready edge may be taken.
    hist_i = hs; excess_i = EW'(exs);
    push_model(hs, exs);
    repeat (18) @(negedge clk);
    vld_i = 1'b0;
    wait_obs(2 * BN);
    a0 = (acc_q.size() > 0) ? acc_q[0] : -100;
    n_cmp++;
    if (acc_q.size() != 2 || acc_q[1] - a0 != 18) begin
      n_err++;
      $display("FAIL b2b_accepts: got %0d accepts (spacing %0d), need 2 spaced 18",
               acc_q.size(), (acc_q.size() > 1) ? acc_q[1] - a0 : -1);
    end
    n_cmp++;
    if (obs_q.size() != 2 * BN) begin
      n_err++;
      $display("FAIL b2b_count: got %0d entries, need %0d", obs_q.size(), 2 * BN);
    end
    if (obs_q.size() >= 17) begin
      n_cmp++;
      if (obs_q[0].cyc != a0 + 2) begin
        n_err++;
        $display("FAIL b2b_first_latency: got edge %0d, need %0d", obs_q[0].cyc, a0 + 2);
      end
      n_cmp++;
      if (obs_q[15].cyc != a0 + 17 || obs_q[15].done !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_done_timing: got edge %0d done=%b, need edge %0d done=1",
                 obs_q[15].cyc, obs_q[15].done, a0 + 17);
      end
      n_cmp++;
      if (obs_q[16].cyc != a0 + 20) begin
        n_err++;
        $display("FAIL b2b_second_latency: got edge %0d, need %0d", obs_q[16].cyc, a0 + 20);
      end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o.vld !== 1'b1 || o.idx != e.idx || o.dat != e.dat || o.done !== e.done) begin
        n_err++;
        $display("FAIL b2b_entry: got vld=%b idx=%0d dat=%0d done=%b, need idx=%0d dat=%0d done=%b",
                 o.vld, o.idx, o.dat, o.done, e.idx, e.dat, e.done);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [HW-1:0] h;
    int ex, n;
    bit seen;
    build_pattern(0, h, ex);
    send_tile(h, ex);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (map_vld_o && map_idx_o == 4'd6) seen = 1'b1;
      n++;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL rstmid_reach_idx6: got no idx 6 entry, need one");
    end
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (map_vld_o !== 1'b0 || done_o !== 1'b0 || map_idx_o !== 4'd0 ||
        map_dat_o !== 4'd0 || rdy_o !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_clear: got vld=%b done=%b idx=%0d dat=%0d rdy=%b, need 0 0 0 0 1",
               map_vld_o, done_o, map_idx_o, map_dat_o, rdy_o);
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    obs_q.delete();
    exp_q.delete();
    repeat (25) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL rstmid_no_output: got %0d entries after reset, need 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_map(0);
    test_map(1);
    test_map(2);
    test_map(3);
    test_back_to_back();
    test_reset_mid();
    test_map(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
